// File: rtl/w80386_bus_read_arbiter_if.sv
// Handshake bundle for the w80386 core read-port arbiter: fetch and data
// requesters on one side, the single bus read port on the other.
interface w80386_bus_read_arbiter_if;
  logic        fetch_read_valid;
  logic [31:0] fetch_read_address;
  logic        fetch_read_ready;
  logic [31:0] fetch_read_data;
  logic        data_read_valid;
  logic [31:0] data_read_address;
  logic        data_read_ready;
  logic [31:0] data_read_data;
  logic        flush;
  logic        bus_read_vaild;
  logic        bus_read_ready;
  logic [31:0] bus_read_address;
  logic [31:0] bus_read_data;
  logic        bus_owner;

  // Arbiter side
  modport slave (
    input  fetch_read_valid, fetch_read_address, data_read_valid, data_read_address,
           flush, bus_read_ready, bus_read_data,
    output fetch_read_ready, fetch_read_data, data_read_ready, data_read_data,
           bus_read_vaild, bus_read_address, bus_owner
  );

  // Requesters and bus slave side
  modport master (
    output fetch_read_valid, fetch_read_address, data_read_valid, data_read_address,
           flush, bus_read_ready, bus_read_data,
    input  fetch_read_ready, fetch_read_data, data_read_ready, data_read_data,
           bus_read_vaild, bus_read_address, bus_owner
  );
endinterface

// File: rtl/w80386_bus_read_arbiter.sv
// Shares the core bus read port between instruction fetch and data reads:
// one outstanding transaction, data priority, starvation limit for fetch.
module w80386_bus_read_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  w80386_bus_read_arbiter_if.slave     bif
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      r_state;
  logic [31:0] r_addr;
  logic        r_owner;
  logic        r_discard;
  logic [3:0]  r_starve_cnt;

  logic w_busy;
  logic w_fetch_ok;
  logic w_force_fetch;
  logic w_grant_fetch;

  assign w_busy        = (r_state == S_BUSY);
  assign w_fetch_ok    = bif.fetch_read_valid & ~bif.flush;
  assign w_force_fetch = (r_starve_cnt == LIMIT) & w_fetch_ok;
  assign w_grant_fetch = w_force_fetch | (~bif.data_read_valid & w_fetch_ok);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_owner      <= 1'b0;
      r_discard    <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_fetch) begin
            r_state      <= S_BUSY;
            r_addr       <= bif.fetch_read_address;
            r_owner      <= 1'b0;
            r_discard    <= 1'b0;
            r_starve_cnt <= '0;
          end else if (bif.data_read_valid) begin
            r_state   <= S_BUSY;
            r_addr    <= bif.data_read_address;
            r_owner   <= 1'b1;
            r_discard <= 1'b0;
            if (bif.fetch_read_valid && (r_starve_cnt < LIMIT))
              r_starve_cnt <= r_starve_cnt + 4'd1;
          end
        end
        S_BUSY: begin
          // A flushed fetch still completes on the bus; only its strobe is dropped.
          if (bif.flush && !r_owner)
            r_discard <= 1'b1;
          if (bif.bus_read_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bif.bus_read_vaild   = w_busy;
  assign bif.bus_read_address = r_addr;
  assign bif.bus_owner        = r_owner;
  assign bif.data_read_ready  = w_busy & bif.bus_read_ready & r_owner;
  assign bif.fetch_read_ready = w_busy & bif.bus_read_ready & ~r_owner & ~r_discard & ~bif.flush;
  assign bif.fetch_read_data  = bif.bus_read_data;
  assign bif.data_read_data   = bif.bus_read_data;

endmodule

// File: tb/tb_w80386_bus_read_arbiter.sv
// Directed self-checking bench for w80386_bus_read_arbiter with a simple
// fixed-latency bus slave model stepped from the stimulus thread.
module tb_w80386_bus_read_arbiter;

  logic clock;
  logic reset;

  w80386_bus_read_arbiter_if bif ();

  w80386_bus_read_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bif   (bif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  int bus_lat  = 0;
  int bus_cnt  = 0;
  logic prev_vaild = 1'b0;
  int n_dready = 0;
  int n_fready = 0;
  logic        g_owner [$];
  logic [31:0] g_addr  [$];
  logic [3:0]  g_starve[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One clock: bus model updates at +1, observation at +2; callers drive after.
  task automatic tick();
    @(posedge clock);
    #1;
    if (bif.bus_read_vaild) begin
      if (bus_cnt == bus_lat) bif.bus_read_ready = 1'b1;
      else begin
        bif.bus_read_ready = 1'b0;
        bus_cnt++;
      end
    end else begin
      bif.bus_read_ready = 1'b0;
      bus_cnt = 0;
    end
    #1;
    if (bif.bus_read_vaild && !prev_vaild) begin
      g_owner.push_back(bif.bus_owner);
      g_addr.push_back(bif.bus_read_address);
      g_starve.push_back(dut.r_starve_cnt);
    end
    prev_vaild = bif.bus_read_vaild;
    if (bif.data_read_ready)  n_dready++;
    if (bif.fetch_read_ready) n_fready++;
  endtask

  task automatic clear_log();
    g_owner.delete();
    g_addr.delete();
    g_starve.delete();
    n_dready = 0;
    n_fready = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bif.fetch_read_valid   = 1'b0;
    bif.fetch_read_address = '0;
    bif.data_read_valid    = 1'b0;
    bif.data_read_address  = '0;
    bif.flush              = 1'b0;
    bif.bus_read_ready     = 1'b0;
    bif.bus_read_data      = '0;
    tick();
    tick();
    reset = 1'b0;
    clear_log();
  endtask

  // Ticks until the chosen ready strobe is seen; returns the tick count.
  task automatic wait_ready(input string tag, input logic is_data, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (is_data ? bif.data_read_ready : bif.fetch_read_ready) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    logic exp_seq [10];

    // Reset state
    do_reset();
    check("rst_vaild", {31'd0, bif.bus_read_vaild}, 32'd0);
    check("rst_addr",  bif.bus_read_address, 32'd0);
    check("rst_owner", {31'd0, bif.bus_owner}, 32'd0);
    check("rst_starve", {28'd0, dut.r_starve_cnt}, 32'd0);
    check("rst_readies", {30'd0, bif.data_read_ready, bif.fetch_read_ready}, 32'd0);

    // Single data read, bus ready two cycles after vaild
    bus_lat = 2;
    bif.bus_read_data     = 32'hDEAD_BEEF;
    bif.data_read_valid   = 1'b1;
    bif.data_read_address = 32'h0000_1000;
    wait_ready("d1", 1'b1, cyc);
    check("d1_latency", cyc, 32'd3);
    check("d1_data",  bif.data_read_data, 32'hDEAD_BEEF);
    check("d1_addr",  bif.bus_read_address, 32'h0000_1000);
    check("d1_owner", {31'd0, bif.bus_owner}, 32'd1);
    bif.data_read_valid = 1'b0;
    tick();
    check("d1_idle", {31'd0, bif.bus_read_vaild}, 32'd0);
    tick();
    check("d1_pulses", n_dready, 32'd1);

    // Both requesters continuously valid: starvation limit forces every fifth grant to fetch
    do_reset();
    bus_lat = 1;
    bif.fetch_read_valid   = 1'b1;
    bif.fetch_read_address = 32'h0000_2000;
    bif.data_read_valid    = 1'b1;
    bif.data_read_address  = 32'h0000_3000;
    for (int i = 0; i < 100 && g_owner.size() < 10; i++) tick();
    check("arb_count", g_owner.size(), 32'd10);
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10 && i < g_owner.size(); i++) begin
      check($sformatf("arb_owner%0d", i), {31'd0, g_owner[i]}, {31'd0, exp_seq[i]});
      check($sformatf("arb_addr%0d", i), g_addr[i], exp_seq[i] ? 32'h0000_3000 : 32'h0000_2000);
    end
    if (g_starve.size() >= 10) begin
      check("arb_starve_f1", {28'd0, g_starve[4]}, 32'd0);
      check("arb_starve_f2", {28'd0, g_starve[9]}, 32'd0);
      check("arb_starve_d4", {28'd0, g_starve[3]}, 32'd4);
    end
    check("arb_fready", n_fready, 32'd1);

    // Flush one cycle before completion of an in-flight fetch
    do_reset();
    bus_lat = 2;
    bif.bus_read_data      = 32'h1111_2222;
    bif.fetch_read_valid   = 1'b1;
    bif.fetch_read_address = 32'h0000_4000;
    tick();
    check("fl_grant", {31'd0, bif.bus_read_vaild}, 32'd1);
    tick();
    check("fl_held", {31'd0, bif.bus_read_vaild}, 32'd1);
    bif.flush = 1'b1;
    tick();
    bif.flush = 1'b0;
    check("fl_busready", {31'd0, bif.bus_read_ready}, 32'd1);
    check("fl_vaild_at_ready", {31'd0, bif.bus_read_vaild}, 32'd1);
    check("fl_suppressed", {31'd0, bif.fetch_read_ready}, 32'd0);
    bif.fetch_read_address = 32'h0000_4100;
    bif.bus_read_data      = 32'h3333_4444;
    wait_ready("fl_next", 1'b0, cyc);
    check("fl_next_addr", bif.bus_read_address, 32'h0000_4100);
    check("fl_next_data", bif.fetch_read_data, 32'h3333_4444);
    check("fl_fready", n_fready, 32'd1);
    bif.fetch_read_valid = 1'b0;
    tick();

    // Flush in IDLE blocks a fetch grant for that cycle only
    do_reset();
    bus_lat = 0;
    bif.fetch_read_valid   = 1'b1;
    bif.fetch_read_address = 32'h0000_5000;
    bif.flush              = 1'b1;
    tick();
    bif.flush = 1'b0;
    check("fi_blocked", {31'd0, bif.bus_read_vaild}, 32'd0);
    tick();
    check("fi_granted", {31'd0, bif.bus_read_vaild}, 32'd1);
    check("fi_owner", {31'd0, bif.bus_owner}, 32'd0);
    check("fi_addr", bif.bus_read_address, 32'h0000_5000);
    check("fi_ready_lat0", {31'd0, bif.fetch_read_ready}, 32'd1);
    bif.fetch_read_valid = 1'b0;
    tick();

    // Asynchronous reset in the middle of a transaction
    do_reset();
    bus_lat = 6;
    bif.fetch_read_valid   = 1'b1;
    bif.fetch_read_address = 32'h0000_6000;
    bif.data_read_valid    = 1'b1;
    bif.data_read_address  = 32'h0000_7000;
    tick();
    bif.fetch_read_valid = 1'b0;
    check("ar_busy", {31'd0, bif.bus_read_vaild}, 32'd1);
    check("ar_starve_pre", {28'd0, dut.r_starve_cnt}, 32'd1);
    tick();
    #1;
    reset = 1'b1;
    bif.bus_read_ready = 1'b1;
    #1;
    check("ar_vaild", {31'd0, bif.bus_read_vaild}, 32'd0);
    check("ar_readies", {30'd0, bif.data_read_ready, bif.fetch_read_ready}, 32'd0);
    check("ar_addr", bif.bus_read_address, 32'd0);
    check("ar_starve", {28'd0, dut.r_starve_cnt}, 32'd0);
    tick();
    reset = 1'b0;
    clear_log();
    tick();
    check("ar_regrant", {31'd0, bif.bus_read_vaild}, 32'd1);
    check("ar_regrant_owner", {31'd0, bif.bus_owner}, 32'd1);
    check("ar_regrant_starve", {28'd0, dut.r_starve_cnt}, 32'd0);
    bif.data_read_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Fetch withdraws before grant: no fetch issued, counter frozen
    do_reset();
    bus_lat = 0;
    bif.fetch_read_valid   = 1'b1;
    bif.fetch_read_address = 32'h0000_8000;
    bif.data_read_valid    = 1'b1;
    bif.data_read_address  = 32'h0000_9000;
    tick();
    bif.fetch_read_valid = 1'b0;
    check("wd_starve1", {28'd0, dut.r_starve_cnt}, 32'd1);
    for (int i = 0; i < 100 && g_owner.size() < 4; i++) tick();
    check("wd_grants", g_owner.size(), 32'd4);
    check("wd_all_data", {31'd0, (g_owner.size() == 4) && (g_owner.sum() with (32'(item)) == 4)}, 32'd1);
    check("wd_starve_frozen", {28'd0, dut.r_starve_cnt}, 32'd1);
    check("wd_fready", n_fready, 32'd0);
    bif.data_read_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
